double_trouble_monitor: RTL and testbench

- Downstream stage for the double_trouble detector. It consumes the detector's single-bit `out` ("at least two of a/b/c/d high") as input `hit`, sampled on qualified clock edges.
- It produces a registered rising-edge pulse, a saturating event counter, and a sustained-condition alarm.
- A 3-state FSM tracks the sampled history of `hit`. This gives the purely combinational detector a time dimension for status and interrupt logic further down the design.

---
 rtl/double_trouble_monitor_if.sv | 24 ++
 rtl/double_trouble_monitor.sv | 109 ++++++++++
 tb/tb_double_trouble_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/double_trouble_monitor_if.sv
// Bus between the double_trouble detector stage and its monitor: sampled hit
// plus qualifiers in, edge/count/alarm status out.
interface double_trouble_monitor_if #(
  parameter int CNT_W = 8
);
  logic             sample_en;
  logic             hit;
  logic             clear;
  logic             edge_pulse;
  logic [CNT_W-1:0] event_count;
  logic             overflow;
  logic             hold_alarm;
  logic [1:0]       state_o;

  modport master (
    output sample_en, hit, clear,
    input  edge_pulse, event_count, overflow, hold_alarm, state_o
  );

  modport slave (
    input  sample_en, hit, clear,
    output edge_pulse, event_count, overflow, hold_alarm, state_o
  );
endinterface

// File: rtl/double_trouble_monitor.sv
// Adds time history to the combinational double_trouble detector: rising-edge
// pulse, saturating event counter with sticky overflow, and sustained-high alarm.
module double_trouble_monitor #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input logic                      clk,
  input logic                      rst,
  double_trouble_monitor_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACTIVE = 2'b01;
  localparam logic [1:0] ALARM  = 2'b10;
  localparam logic [7:0] HOLD   = 8'(HOLD_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             alarm_q, alarm_d;
  logic             pulse_q, pulse_d;
  logic             count_ev;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    alarm_d  = alarm_q;
    pulse_d  = 1'b0;
    count_ev = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      run_d   = '0;
      alarm_d = 1'b0;
    end else if (state_q == 2'b11) begin
      // Illegal encoding recovers regardless of sample_en.
      state_d = IDLE;
      run_d   = '0;
      alarm_d = 1'b0;
    end else if (bus.sample_en) begin
      if (!bus.hit) begin
        state_d = IDLE;
        run_d   = '0;
        alarm_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d  = ACTIVE;
            run_d    = 8'd1;
            pulse_d  = 1'b1;
            count_ev = 1'b1;
          end
          ACTIVE: begin
            // 9-bit compare so run never wraps even at HOLD_CYCLES=255.
            if ({1'b0, run_q} + 9'd1 == {1'b0, HOLD}) begin
              state_d = ALARM;
              run_d   = HOLD;
              alarm_d = 1'b1;
            end else begin
              run_d = run_q + 8'd1;
            end
          end
          default: begin
            state_d = ALARM;
            run_d   = HOLD;
            alarm_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (bus.clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (count_ev) begin
      if (cnt_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
      else                        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      alarm_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      alarm_q <= alarm_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.edge_pulse  = pulse_q;
  assign bus.event_count = cnt_q;
  assign bus.overflow    = ovf_q;
  assign bus.hold_alarm  = alarm_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_double_trouble_monitor.sv
// Directed bench: one monitor with CNT_W=8 and one with CNT_W=3 share stimulus.
module tb_double_trouble_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errs   = 0;

  always #5 clk = ~clk;

  double_trouble_monitor_if #(.CNT_W(8)) ia ();
  double_trouble_monitor_if #(.CNT_W(3)) ib ();

  double_trouble_monitor #(.CNT_W(8), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave));
  double_trouble_monitor #(.CNT_W(3), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic smp(input logic en, input logic h, input logic cl);
    ia.sample_en = en; ia.hit = h; ia.clear = cl;
    ib.sample_en = en; ib.hit = h; ib.clear = cl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic det(input logic [3:0] v);
    return (int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3])) >= 2;
  endfunction

  logic [1:0] st2 [7]  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
  logic       al2 [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] st6 [16] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01,
                           2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};

  initial begin
    smp(1'b0, 1'b0, 1'b0);
    chk("rst_state", ia.state_o, 0);
    chk("rst_cnt", ia.event_count, 0);
    rst = 1'b0;

    // 1: build count=5 with alarm, then async reset mid-cycle
    for (int k = 0; k < 4; k++) begin
      smp(1'b1, 1'b1, 1'b0);
      smp(1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) smp(1'b1, 1'b1, 1'b0);
    chk("pre_cnt", ia.event_count, 5);
    chk("pre_alarm", ia.hold_alarm, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnt", ia.event_count, 0);
    chk("arst_alarm", ia.hold_alarm, 0);
    chk("arst_state", ia.state_o, 0);
    chk("arst_ovf", ia.overflow, 0);
    chk("arst_pulse", ia.edge_pulse, 0);
    @(negedge clk) rst = 1'b0;
    smp(1'b1, 1'b0, 1'b0);
    chk("t1_p0", ia.edge_pulse, 0);
    smp(1'b1, 1'b1, 1'b0);
    chk("t1_p1", ia.edge_pulse, 1);
    chk("t1_cnt1", ia.event_count, 1);
    smp(1'b1, 1'b0, 1'b0);
    chk("t1_p2", ia.edge_pulse, 0);
    chk("t1_cnt2", ia.event_count, 1);

    // 2: hold alarm
    smp(1'b1, 1'b0, 1'b1);
    chk("clr_cnt", ia.event_count, 0);
    for (int k = 0; k < 7; k++) begin
      smp(1'b1, (k < 6), 1'b0);
      chk($sformatf("t2_state%0d", k), ia.state_o, st2[k]);
      chk($sformatf("t2_alarm%0d", k), ia.hold_alarm, al2[k]);
      chk($sformatf("t2_pulse%0d", k), ia.edge_pulse, (k == 0));
    end
    chk("t2_cnt", ia.event_count, 1);

    // 3: sample_en gap does not break the run
    smp(1'b1, 1'b0, 1'b1);
    smp(1'b1, 1'b1, 1'b0);
    smp(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      smp(1'b0, k[0], 1'b0);
      chk($sformatf("t3_gap_pulse%0d", k), ia.edge_pulse, 0);
      chk($sformatf("t3_gap_state%0d", k), ia.state_o, 1);
    end
    smp(1'b1, 1'b1, 1'b0);
    chk("t3_alarm3", ia.hold_alarm, 0);
    smp(1'b1, 1'b1, 1'b0);
    chk("t3_alarm4", ia.hold_alarm, 1);
    chk("t3_cnt", ia.event_count, 1);
    smp(1'b1, 1'b0, 1'b0);

    // 4: saturation on the CNT_W=3 instance
    smp(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      smp(1'b1, 1'b1, 1'b0);
      chk($sformatf("t4_pulse%0d", k), ib.edge_pulse, 1);
      chk($sformatf("t4_cnt%0d", k), ib.event_count, (k > 7) ? 7 : k);
      chk($sformatf("t4_ovf%0d", k), ib.overflow, (k >= 8));
      smp(1'b1, 1'b0, 1'b0);
    end
    chk("t4_ovf_sticky", ib.overflow, 1);

    // 5: clear while in ALARM with hit still high
    for (int k = 0; k < 5; k++) smp(1'b1, 1'b1, 1'b0);
    chk("t5_pre_state", ia.state_o, 2);
    smp(1'b1, 1'b1, 1'b1);
    chk("t5_cnt", ia.event_count, 0);
    chk("t5_ovf", ib.overflow, 0);
    chk("t5_alarm", ia.hold_alarm, 0);
    chk("t5_state", ia.state_o, 0);
    smp(1'b1, 1'b1, 1'b0);
    chk("t5_pulse", ia.edge_pulse, 1);
    chk("t5_cnt1", ia.event_count, 1);
    chk("t5_state1", ia.state_o, 1);

    // 6: drive from the detector, a/b/c/d ascending
    smp(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      smp(1'b1, det(v), 1'b0);
      chk($sformatf("t6_pulse%0d", i), ia.edge_pulse, (i == 3 || i == 5 || i == 9));
      chk($sformatf("t6_state%0d", i), ia.state_o, st6[i]);
      chk($sformatf("t6_alarm%0d", i), ia.hold_alarm, (i >= 12));
    end
    chk("t6_cnt", ia.event_count, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
